mc_incn_pipe: RTL and testbench

MC_INCN_PIPE -- requirements
Module: mc_incn_pipe

---
 rtl/mc_incn_pipe_pkg.sv | 19 +
 rtl/mc_incn_seg.sv | 42 ++++
 rtl/mc_incn_pipe.sv | 133 +++++++++++++
 tb/tb_mc_incn_pipe.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_incn_pipe_pkg.sv
// ---------------------------------------------------------------------------
// mc_incn_pipe_pkg
// Shared defaults for the segmented increment/decrement pipeline, plus the
// helper that derives the carry-segment width from the operand width.
// Imported by mc_incn_pipe and mc_incn_seg.
// ---------------------------------------------------------------------------
package mc_incn_pipe_pkg;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_NSEG   = 2;
  localparam int DEF_STEP_W = 8;

  // Width of one carry segment. WIDTH must be a multiple of NSEG and the
  // step must fit inside segment 0.
  function automatic int seg_width(input int width, input int nseg);
    return width / nseg;
  endfunction

endpackage

// File: rtl/mc_incn_seg.sv
// ---------------------------------------------------------------------------
// mc_incn_seg
// One carry segment: SEG_W-bit add or subtract of a segment operand and a
// step operand, with carry-in (add) or borrow-in (subtract).
// Ports:
//   seg_a    - segment of the base operand
//   seg_b    - step bits for this segment (zero above segment 0)
//   seg_cin  - carry-in (inc) or borrow-in (dec) from the lower segment
//   seg_dec  - 1 = subtract, 0 = add
//   seg_sum  - segment result
//   seg_cout - carry-out (inc) or borrow-out (dec)
// ---------------------------------------------------------------------------
module mc_incn_seg
  import mc_incn_pipe_pkg::*;
#(
  parameter int SEG_W = seg_width(DEF_WIDTH, DEF_NSEG)
) (
  input  logic [SEG_W-1:0] seg_a,
  input  logic [SEG_W-1:0] seg_b,
  input  logic             seg_cin,
  input  logic             seg_dec,
  output logic [SEG_W-1:0] seg_sum,
  output logic             seg_cout
);

  logic [SEG_W:0] ext;

  // One extra bit on top of the segment: for an add it is the carry, for a
  // subtract the wrap below zero sets it, which is exactly the borrow.
  always_comb begin
    ext = '0;
    if (seg_dec) begin
      ext = {1'b0, seg_a} - {1'b0, seg_b} - {{SEG_W{1'b0}}, seg_cin};
    end else begin
      ext = {1'b0, seg_a} + {1'b0, seg_b} + {{SEG_W{1'b0}}, seg_cin};
    end
  end

  assign seg_sum  = ext[SEG_W-1:0];
  assign seg_cout = ext[SEG_W];

endmodule

// File: rtl/mc_incn_pipe.sv
// ---------------------------------------------------------------------------
// mc_incn_pipe
// Pipelined increment/decrement by an unsigned step. The operand is split
// into NSEG carry segments; stage k resolves segment k using the carry or
// borrow registered by stage k-1, so latency is NSEG cycles.
// Ports:
//   clk, rst_n           - clock, asynchronous active-low reset
//   in_valid / in_ready  - request handshake
//   in_data, in_step     - base operand and unsigned step
//   in_dec               - 1 = decrement, 0 = increment
//   out_valid / out_ready- result handshake
//   out_data, out_carry  - result and carry/borrow out of the MSB
// ---------------------------------------------------------------------------
module mc_incn_pipe
  import mc_incn_pipe_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int NSEG   = DEF_NSEG,
  parameter int STEP_W = DEF_STEP_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  input  logic [STEP_W-1:0] in_step,
  input  logic              in_dec,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic              out_carry
);

  localparam int SEG_W = seg_width(WIDTH, NSEG);

  // Per stage: data_q[k] holds segments 0..k already resolved and the raw
  // upper segments still waiting for their carry (the skew registers).
  logic [NSEG-1:0]  valid_q, valid_d;
  logic [WIDTH-1:0] data_q  [NSEG];
  logic [WIDTH-1:0] data_d  [NSEG];
  logic             carry_q [NSEG];
  logic             carry_d [NSEG];
  logic             dec_q   [NSEG];
  logic             dec_d   [NSEG];

  logic [SEG_W-1:0] seg_a    [NSEG];
  logic [SEG_W-1:0] seg_b    [NSEG];
  logic [SEG_W-1:0] seg_sum  [NSEG];
  logic             seg_cin  [NSEG];
  logic             seg_dec  [NSEG];
  logic             seg_cout [NSEG];

  logic adv;

  // Whole pipe moves together; the only combinational path through the
  // block is out_ready -> in_ready.
  assign adv      = !valid_q[NSEG-1] || out_ready;
  assign in_ready = adv;

  // Stage 0 works on the incoming request, later stages on the previous
  // stage's registers. The step only touches segment 0.
  for (genvar k = 0; k < NSEG; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign seg_a[k]   = in_data[SEG_W-1:0];
      assign seg_b[k]   = SEG_W'(in_step);
      assign seg_cin[k] = 1'b0;
      assign seg_dec[k] = in_dec;
    end else begin : g_rest
      assign seg_a[k]   = data_q[k-1][k*SEG_W +: SEG_W];
      assign seg_b[k]   = '0;
      assign seg_cin[k] = carry_q[k-1];
      assign seg_dec[k] = dec_q[k-1];
    end

    mc_incn_seg #(.SEG_W(SEG_W)) u_seg (
      .seg_a    (seg_a[k]),
      .seg_b    (seg_b[k]),
      .seg_cin  (seg_cin[k]),
      .seg_dec  (seg_dec[k]),
      .seg_sum  (seg_sum[k]),
      .seg_cout (seg_cout[k])
    );
  end

  // Next-state: on advance every valid bit shifts (bubbles included); the
  // payload is only reloaded when a real request enters the stage, so
  // bubbles leave the data registers quiet.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    carry_d = carry_q;
    dec_d   = dec_q;
    if (adv) begin
      valid_d[0] = in_valid;
      if (in_valid) begin
        data_d[0]              = in_data;
        data_d[0][SEG_W-1:0]   = seg_sum[0];
        carry_d[0]             = seg_cout[0];
        dec_d[0]               = in_dec;
      end
      for (int k = 1; k < NSEG; k++) begin
        valid_d[k] = valid_q[k-1];
        if (valid_q[k-1]) begin
          data_d[k]                   = data_q[k-1];
          data_d[k][k*SEG_W +: SEG_W] = seg_sum[k];
          carry_d[k]                  = seg_cout[k];
          dec_d[k]                    = dec_q[k-1];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int k = 0; k < NSEG; k++) begin
        data_q[k]  <= '0;
        carry_q[k] <= 1'b0;
        dec_q[k]   <= 1'b0;
      end
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      carry_q <= carry_d;
      dec_q   <= dec_d;
    end
  end

  assign out_valid = valid_q[NSEG-1];
  assign out_data  = data_q[NSEG-1];
  assign out_carry = carry_q[NSEG-1];

endmodule

// File: tb/tb_mc_incn_pipe.sv
// ---------------------------------------------------------------------------
// tb_mc_incn_pipe
// Bench for mc_incn_pipe: a default 32-bit/2-segment instance driven through
// a scoreboard, plus a 64-bit/4-segment instance for the wide carry chain.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mc_incn_pipe;

  typedef struct {
    logic [31:0] data;
    logic        carry;
  } exp_t;

  typedef struct {
    logic [31:0] data;
    logic [7:0]  step;
    logic        dec;
    logic [31:0] exp_data;
    logic        exp_carry;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [7:0]  in_step;
  logic        in_dec;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_carry;

  logic        in_valid64;
  logic        in_ready64;
  logic [63:0] in_data64;
  logic [15:0] in_step64;
  logic        in_dec64;
  logic        out_valid64;
  logic        out_ready64;
  logic [63:0] out_data64;
  logic        out_carry64;

  int   checks = 0;
  int   errors = 0;
  int   cycle = 0;
  int   total_out = 0;
  int   stall_cycles = 0;
  bit   collect = 0;
  exp_t sb[$];
  int   out_cycles[$];
  exp_t mon_e;
  vec_t vecs[10];

  mc_incn_pipe u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_step   (in_step),
    .in_dec    (in_dec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_carry (out_carry)
  );

  mc_incn_pipe #(.WIDTH(64), .NSEG(4), .STEP_W(16)) u_dut64 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid64),
    .in_ready  (in_ready64),
    .in_data   (in_data64),
    .in_step   (in_step64),
    .in_dec    (in_dec64),
    .out_valid (out_valid64),
    .out_ready (out_ready64),
    .out_data  (out_data64),
    .out_carry (out_carry64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle++;

  // Plain full-width arithmetic as the reference result.
  function automatic exp_t model(input logic [31:0] a, input logic [7:0] s, input logic d);
    logic [32:0] r;
    exp_t e;
    if (d) r = {1'b0, a} - {25'd0, s};
    else   r = {1'b0, a} + {25'd0, s};
    e.data  = r[31:0];
    e.carry = r[32];
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Present one request and hold it until the handshake completes; the
  // expected result joins the scoreboard on the accepting edge.
  task automatic applyStimulus(input logic [31:0] d, input logic [7:0] s,
                               input logic dc, input exp_t e);
    int waits;
    bit acc;
    in_valid = 1'b1;
    in_data  = d;
    in_step  = s;
    in_dec   = dc;
    waits    = 0;
    acc      = 1'b0;
    while (!acc && waits < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (!acc) waits++;
    end
    if (acc) begin
      sb.push_back(e);
    end else begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: got no handshake in %0d cycles, expected acceptance", waits);
    end
    stall_cycles += waits;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    in_valid = 1'b0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("drain_queue_empty", 64'(sb.size()), 64'd0);
  endtask

  // Scoreboard side: every completed output handshake must match the oldest
  // outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      total_out++;
      if (collect) out_cycles.push_back(cycle);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_output: got data %h carry %b, expected no output", out_data, out_carry);
      end else begin
        mon_e = sb.pop_front();
        checkOutput("result_data", 64'(out_data), 64'(mon_e.data));
        checkOutput("result_carry", 64'(out_carry), 64'(mon_e.carry));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int out_before;
    logic [31:0] rd;
    logic [7:0]  rs;
    logic        rdec;
    exp_t        e;

    vecs[0] = '{32'h0000FFFF, 8'h01, 1'b0, 32'h00010000, 1'b0};
    vecs[1] = '{32'hFFFFFFFF, 8'h01, 1'b0, 32'h00000000, 1'b1};
    vecs[2] = '{32'h00000000, 8'h01, 1'b1, 32'hFFFFFFFF, 1'b1};
    vecs[3] = '{32'h12345678, 8'hFF, 1'b0, 32'h12345777, 1'b0};
    vecs[4] = '{32'h00010000, 8'h01, 1'b1, 32'h0000FFFF, 1'b0};
    vecs[5] = '{32'hFFFFFF00, 8'hFF, 1'b0, 32'hFFFFFFFF, 1'b0};
    vecs[6] = '{32'h00000005, 8'h10, 1'b1, 32'hFFFFFFF5, 1'b1};
    vecs[7] = '{32'h80000000, 8'h01, 1'b1, 32'h7FFFFFFF, 1'b0};
    vecs[8] = '{32'hFFFFFFF0, 8'h20, 1'b0, 32'h00000010, 1'b1};
    vecs[9] = '{32'h0000FF00, 8'hFF, 1'b0, 32'h0000FFFF, 1'b0};

    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_data     = '0;
    in_step     = '0;
    in_dec      = 1'b0;
    out_ready   = 1'b1;
    in_valid64  = 1'b0;
    in_data64   = '0;
    in_step64   = '0;
    in_dec64    = 1'b0;
    out_ready64 = 1'b1;

    // Reset and the idle state that follows release.
    @(posedge clk);
    #1;
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("post_reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("post_reset_out_data", 64'(out_data), 64'd0);
    checkOutput("post_reset_out_carry", 64'(out_carry), 64'd0);
    checkOutput("post_reset_in_ready", 64'(in_ready), 64'd1);

    // Wide instance: carry runs through all four segments, latency 4.
    in_valid64 = 1'b1;
    in_data64  = 64'h0000FFFFFFFFFFFF;
    in_step64  = 16'hFFFF;
    in_dec64   = 1'b0;
    checkOutput("w64_in_ready", 64'(in_ready64), 64'd1);
    @(posedge clk);
    #1;
    in_valid64 = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      if (i < 4) begin
        checkOutput("w64_valid_early", 64'(out_valid64), 64'd0);
        @(posedge clk);
        #1;
      end else begin
        checkOutput("w64_valid_lat4", 64'(out_valid64), 64'd1);
        checkOutput("w64_data", out_data64, 64'h000100000000FFFE);
        checkOutput("w64_carry", 64'(out_carry64), 64'd0);
      end
    end
    idle(2);

    // Latency 2 and carry crossing the segment boundary.
    e.data = 32'h00010000;
    e.carry = 1'b0;
    applyStimulus(32'h0000FFFF, 8'h01, 1'b0, e);
    in_valid = 1'b0;
    checkOutput("lat_valid_after1", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    checkOutput("lat_valid_after2", 64'(out_valid), 64'd1);
    checkOutput("lat_data", 64'(out_data), 64'h00010000);
    checkOutput("lat_carry", 64'(out_carry), 64'd0);
    waitDrain();

    // Directed vectors back to back.
    for (int i = 0; i < 10; i++) begin
      e.data  = vecs[i].exp_data;
      e.carry = vecs[i].exp_carry;
      applyStimulus(vecs[i].data, vecs[i].step, vecs[i].dec, e);
    end
    waitDrain();

    // 100 random requests, one per cycle in and out.
    stall_cycles = 0;
    out_cycles.delete();
    collect = 1'b1;
    out_before = total_out;
    for (int i = 0; i < 100; i++) begin
      rd   = $urandom;
      rs   = 8'($urandom_range(0, 255));
      rdec = 1'($urandom_range(0, 1));
      applyStimulus(rd, rs, rdec, model(rd, rs, rdec));
    end
    waitDrain();
    collect = 1'b0;
    checkOutput("rand_no_input_stall", 64'(stall_cycles), 64'd0);
    checkOutput("rand_output_count", 64'(total_out - out_before), 64'd100);
    if (out_cycles.size() == 100)
      checkOutput("rand_output_span", 64'(out_cycles[99] - out_cycles[0]), 64'd99);
    else
      checkOutput("rand_output_samples", 64'(out_cycles.size()), 64'd100);

    // Backpressure with a full pipe: outputs frozen, nothing lost.
    out_before = total_out;
    out_ready = 1'b0;
    applyStimulus(32'h0000FFFE, 8'h03, 1'b0, model(32'h0000FFFE, 8'h03, 1'b0));
    applyStimulus(32'h00000010, 8'h20, 1'b1, model(32'h00000010, 8'h20, 1'b1));
    in_valid = 1'b1;
    in_data  = 32'hAAAA5555;
    in_step  = 8'h11;
    in_dec   = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("stall_in_ready", 64'(in_ready), 64'd0);
      checkOutput("stall_out_valid", 64'(out_valid), 64'd1);
      checkOutput("stall_out_data", 64'(out_data), 64'h00010001);
      checkOutput("stall_out_carry", 64'(out_carry), 64'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    applyStimulus(32'hAAAA5555, 8'h11, 1'b0, model(32'hAAAA5555, 8'h11, 1'b0));
    waitDrain();
    idle(3);
    checkOutput("stall_output_count", 64'(total_out - out_before), 64'd3);

    // Reset with two requests in flight: they vanish, nothing stale follows.
    applyStimulus(32'h11111111, 8'h01, 1'b0, model(32'h11111111, 8'h01, 1'b0));
    applyStimulus(32'h22222222, 8'h02, 1'b0, model(32'h22222222, 8'h02, 1'b0));
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_out_valid", 64'(out_valid), 64'd0);
    sb.delete();
    in_valid = 1'b1;
    in_data  = 32'h33333333;
    in_step  = 8'h03;
    in_dec   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("rerst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rerst_out_data", 64'(out_data), 64'd0);
    checkOutput("rerst_in_ready", 64'(in_ready), 64'd1);
    out_before = total_out;
    idle(6);
    checkOutput("rerst_no_stale", 64'(total_out - out_before), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
